alu_serial_exec: RTL and testbench
==================================

Name: alu_serial_exec

Overview:
- Execute-stage ALU that directly consumes the 4-bit ALU operation code produced by the ALU control unit.
- Takes operands A/B from the register file and immediate mux.
- Returns a registered result, a zero flag and a branch-taken flag.
- Logic/arithmetic ops complete in one cycle; SLL/SRL use an iterative 1-bit-per-cycle shifter under a small FSM with start/done handshake, so the core can stall on shifts.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- SHAMT_WIDTH, 5, shift-amount bits taken from B_i[SHAMT_WIDTH-1:0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  request; sampled only when ready_o=1.
- ALU_Operation_i  input  4  operation code (encoding below).
- A_i  input  DATA_WIDTH  operand A (rs1 or PC).
- B_i  input  DATA_WIDTH  operand B (rs2 or immediate).
- ready_o  output  1  high only in IDLE.
- busy_o  output  1  high in SHIFT.
- done_o  output  1  one-cycle pulse; result valid.
- ALU_Result_o  output  DATA_WIDTH  registered result, held until the next accepted start.
- zero_o  output  1  registered (ALU_Result_o==0).
- branch_taken_o  output  1  registered branch decision.

Behaviour:
- Reset (async, reset=0): state=IDLE; ALU_Result_o=0, zero_o=0, branch_taken_o=0, done_o=0, busy_o=0; shift count=0. ready_o=1 once reset is released.
- Reset asserted mid-shift aborts the operation; no done_o pulse.
- Opcodes, results wrap modulo 2^DATA_WIDTH:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 OR.
  - 3 AND.
  - 4 XOR.
  - 5 LUI: B.
  - 6 SLL: A<<B[4:0].
  - 7 SRL: logical A>>B[4:0].
  - 8 BEQ: A-B, branch_taken=(A==B).
  - 9 BNE: A-B, branch_taken=(A!=B).
  - 10 JAL: A+4.
  - 15 AUIPC: A+B.
  - 11-14: result 0, branch_taken 0.
  - branch_taken_o=0 for every non-branch opcode.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start_i=1 with non-shift op: result/flags registered at that edge; go to DONE.
  - start_i=1 with shift op: acc<=A_i, cnt<=B_i[4:0], direction latched. cnt==0 goes straight to DONE with result=A_i. Otherwise go to SHIFT.
  - start_i=0: stay in IDLE.
- SHIFT: each cycle acc shifts 1 bit (SLL left, SRL right, zero fill) and cnt decrements. When cnt reaches 0 after a shift, ALU_Result_o<=acc, zero_o updated, go to DONE.
- DONE: done_o=1 for exactly this cycle, then IDLE unconditionally.
- Operands and opcode are captured at acceptance; later changes to A_i/B_i/ALU_Operation_i have no effect.
- Latency from accepting edge to done_o high:
  - non-shift and zero-amount shift: 1 cycle.
  - shift by N>0: N+1 cycles.
- Throughput: one op per 2 cycles minimum. start_i held high in DONE is ignored and accepted in the following IDLE cycle.
- start_i while busy or in DONE is ignored, with no queueing.
- ALU_Result_o, zero_o and branch_taken_o change only on the edge entering DONE (or on reset).

Test Plan:
- Reset mid-SHIFT (SLL by 20, reset low at cycle 5) -> outputs 0 immediately, no done_o, ready_o=1 after release; next ADD 7+5 -> result 12.
- ADD A=0xFFFFFFFF, B=1 -> done_o 1 cycle later, result 0, zero_o=1; SUB A=5,B=7 -> 0xFFFFFFFE, zero_o=0.
- SLL A=0x00000001, B=31 -> busy_o for 31 cycles, done_o at cycle 32, result 0x80000000.
- SRL A=0x80000000, B=0 -> done_o after 1 cycle, result 0x80000000.
- BEQ A=B=0x1234 -> branch_taken_o=1, zero_o=1; BNE same operands -> branch_taken_o=0; JAL A=0x100 -> 0x104; LUI B=0xABCDE000 -> 0xABCDE000; opcode 12 -> result 0.
- start_i pulsed during SHIFT with a different op and A_i changed mid-shift -> ignored; original shift result unchanged; next op accepted only when ready_o=1.

Source files
------------

// File: rtl/alu_serial_exec_if.sv
// Handshake and operand/result bundle between the issue logic and the serial ALU.
interface alu_serial_exec_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic                  ready_o;
  logic                  busy_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] ALU_Result_o;
  logic                  zero_o;
  logic                  branch_taken_o;

  modport master (
    output start_i, ALU_Operation_i, A_i, B_i,
    input  ready_o, busy_o, done_o, ALU_Result_o, zero_o, branch_taken_o
  );

  modport slave (
    input  start_i, ALU_Operation_i, A_i, B_i,
    output ready_o, busy_o, done_o, ALU_Result_o, zero_o, branch_taken_o
  );
endinterface

// File: rtl/alu_serial_exec.sv
// Execute-stage ALU: single-cycle logic/arith ops, 1-bit-per-cycle SLL/SRL
// under a start/done handshake so the pipeline can stall on shifts.
module alu_serial_exec #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SHAMT_WIDTH = 5
) (
  input  logic              clk,
  input  logic              reset,
  alu_serial_exec_if.slave  bus
);

  localparam int unsigned OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_ADD   = 4'd0;
  localparam logic [OP_WIDTH-1:0] OP_SUB   = 4'd1;
  localparam logic [OP_WIDTH-1:0] OP_OR    = 4'd2;
  localparam logic [OP_WIDTH-1:0] OP_AND   = 4'd3;
  localparam logic [OP_WIDTH-1:0] OP_XOR   = 4'd4;
  localparam logic [OP_WIDTH-1:0] OP_LUI   = 4'd5;
  localparam logic [OP_WIDTH-1:0] OP_SLL   = 4'd6;
  localparam logic [OP_WIDTH-1:0] OP_SRL   = 4'd7;
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = 4'd8;
  localparam logic [OP_WIDTH-1:0] OP_BNE   = 4'd9;
  localparam logic [OP_WIDTH-1:0] OP_JAL   = 4'd10;
  localparam logic [OP_WIDTH-1:0] OP_AUIPC = 4'd15;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   dir_q, dir_d;       // 1 = shift right
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   br_q, br_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;

  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_br;
  logic                   is_shift;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [DATA_WIDTH-1:0]  acc_shifted;

  assign is_shift    = (bus.ALU_Operation_i == OP_SLL) || (bus.ALU_Operation_i == OP_SRL);
  assign shamt       = bus.B_i[SHAMT_WIDTH-1:0];
  assign acc_shifted = dir_q ? (acc_q >> 1) : (acc_q << 1);

  // Single-cycle result and branch decision for the presented operands.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (bus.ALU_Operation_i)
      OP_ADD, OP_AUIPC: alu_res = bus.A_i + bus.B_i;
      OP_SUB:           alu_res = bus.A_i - bus.B_i;
      OP_OR:            alu_res = bus.A_i | bus.B_i;
      OP_AND:           alu_res = bus.A_i & bus.B_i;
      OP_XOR:           alu_res = bus.A_i ^ bus.B_i;
      OP_LUI:           alu_res = bus.B_i;
      OP_BEQ: begin
        alu_res = bus.A_i - bus.B_i;
        alu_br  = (bus.A_i == bus.B_i);
      end
      OP_BNE: begin
        alu_res = bus.A_i - bus.B_i;
        alu_br  = (bus.A_i != bus.B_i);
      end
      OP_JAL:           alu_res = bus.A_i + DATA_WIDTH'(4);
      default:          alu_res = '0;
    endcase
  end

  // Next-state and datapath update; results only move on entry to DONE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;
    zero_d   = zero_q;
    br_d     = br_q;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (is_shift) begin
            acc_d = bus.A_i;
            cnt_d = shamt;
            dir_d = (bus.ALU_Operation_i == OP_SRL);
            if (shamt == '0) begin
              result_d = bus.A_i;
              zero_d   = (bus.A_i == '0);
              br_d     = 1'b0;
              state_d  = DONE;
            end else begin
              state_d  = SHIFT;
            end
          end else begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            br_d     = alu_br;
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = acc_shifted;
          zero_d   = (acc_shifted == '0);
          br_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d  = (state_d == DONE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d == SHIFT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      br_q     <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      br_q     <= br_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.ready_o        = ready_q;
  assign bus.busy_o         = busy_q;
  assign bus.done_o         = done_q;
  assign bus.ALU_Result_o   = result_q;
  assign bus.zero_o         = zero_q;
  assign bus.branch_taken_o = br_q;

endmodule

// File: tb/tb_alu_serial_exec.sv
// Directed bench for alu_serial_exec: vector table plus multi-cycle corner sequences.
module tb_alu_serial_exec;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  alu_serial_exec_if #(.DATA_WIDTH(32)) bus ();

  alu_serial_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        br;
    int          lat;
  } vec_t;

  localparam int NVEC = 19;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op from a negedge; returns cycles until done_o seen (negedge sampling).
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    int w;
    w = 0;
    while (!bus.ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_before_start", 32'(bus.ready_o), 32'd1);
    bus.ALU_Operation_i = op;
    bus.A_i             = a;
    bus.B_i             = b;
    bus.start_i         = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.A_i     = ~a;
    bus.B_i     = ~b;
    lat = 1;
    while (!bus.done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int cnt;
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[1]  = '{4'd1,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
    vecs[2]  = '{4'd2,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0, 1};
    vecs[3]  = '{4'd3,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1};
    vecs[4]  = '{4'd4,  32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 1};
    vecs[5]  = '{4'd5,  32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0, 1'b0, 1};
    vecs[6]  = '{4'd6,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0, 1'b0, 32};
    vecs[7]  = '{4'd7,  32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0, 1};
    vecs[8]  = '{4'd7,  32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b0, 1'b0, 5};
    vecs[9]  = '{4'd6,  32'h0000_0001, 32'h0000_0020, 32'h0000_0001, 1'b0, 1'b0, 1};
    vecs[10] = '{4'd8,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b1, 1};
    vecs[11] = '{4'd9,  32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[12] = '{4'd8,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1};
    vecs[13] = '{4'd9,  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b1, 1};
    vecs[14] = '{4'd10, 32'h0000_0100, 32'h0000_0055, 32'h0000_0104, 1'b0, 1'b0, 1};
    vecs[15] = '{4'd15, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 1'b0, 1'b0, 1};
    vecs[16] = '{4'd12, 32'h0000_0005, 32'h0000_0006, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[17] = '{4'd11, 32'h0000_0009, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1};
    vecs[18] = '{4'd7,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 32};

    bus.start_i         = 1'b0;
    bus.ALU_Operation_i = 4'd0;
    bus.A_i             = 32'd0;
    bus.B_i             = 32'd0;
    reset               = 1'b0;

    // Reset values
    #3;
    check("rst_result", bus.ALU_Result_o, 32'd0);
    check("rst_zero",   32'(bus.zero_o), 32'd0);
    check("rst_branch", 32'(bus.branch_taken_o), 32'd0);
    check("rst_done",   32'(bus.done_o), 32'd0);
    check("rst_busy",   32'(bus.busy_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(bus.ready_o), 32'd1);

    // Vector table
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_result", i), bus.ALU_Result_o, vecs[i].res);
      check($sformatf("v%0d_zero", i),   32'(bus.zero_o), 32'(vecs[i].z));
      check($sformatf("v%0d_branch", i), 32'(bus.branch_taken_o), 32'(vecs[i].br));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done_o), 32'd0);
    end

    // SLL by 31: busy count
    bus.ALU_Operation_i = 4'd6;
    bus.A_i             = 32'h1;
    bus.B_i             = 32'd31;
    bus.start_i         = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    cnt = 0;
    lat = 1;
    while (!bus.done_o && lat < 100) begin
      if (bus.busy_o) cnt++;
      @(negedge clk);
      lat++;
    end
    check("sll31_busy_cycles", 32'(cnt), 32'd31);
    check("sll31_latency",     32'(lat), 32'd32);
    check("sll31_result",      bus.ALU_Result_o, 32'h8000_0000);
    @(negedge clk);

    // Reset mid-shift: SLL by 20, reset at cycle 5
    bus.ALU_Operation_i = 4'd6;
    bus.A_i             = 32'h1;
    bus.B_i             = 32'd20;
    bus.start_i         = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int k = 1; k < 5; k++) @(negedge clk);
    check("pre_rst_busy",   32'(bus.busy_o), 32'd1);
    check("pre_rst_result", bus.ALU_Result_o, 32'h8000_0000);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_result", bus.ALU_Result_o, 32'd0);
    check("midrst_zero",   32'(bus.zero_o), 32'd0);
    check("midrst_branch", 32'(bus.branch_taken_o), 32'd0);
    check("midrst_busy",   32'(bus.busy_o), 32'd0);
    check("midrst_done",   32'(bus.done_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("inrst_done", 32'(bus.done_o), 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    check("postrst_ready", 32'(bus.ready_o), 32'd1);
    cnt = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done_o) cnt++;
      @(negedge clk);
    end
    check("aborted_no_done", 32'(cnt), 32'd0);
    run_op(4'd0, 32'd7, 32'd5, lat);
    check("add_after_rst_result",  bus.ALU_Result_o, 32'd12);
    check("add_after_rst_latency", 32'(lat), 32'd1);
    @(negedge clk);

    // start pulsed mid-shift with another op and new A: ignored
    bus.ALU_Operation_i = 4'd6;
    bus.A_i             = 32'h3;
    bus.B_i             = 32'd10;
    bus.start_i         = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    lat = 1;
    check("mid_busy",      32'(bus.busy_o), 32'd1);
    check("mid_ready",     32'(bus.ready_o), 32'd0);
    check("mid_held_res",  bus.ALU_Result_o, 32'd12);
    @(negedge clk);
    @(negedge clk);
    lat = 3;
    bus.ALU_Operation_i = 4'd0;
    bus.A_i             = 32'h0000_FFFF;
    bus.B_i             = 32'h1;
    bus.start_i         = 1'b1;
    @(negedge clk);
    lat++;
    bus.start_i = 1'b0;
    while (!bus.done_o && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("ign_latency", 32'(lat), 32'd11);
    check("ign_result",  bus.ALU_Result_o, 32'h0000_0C00);
    check("ign_zero",    32'(bus.zero_o), 32'd0);
    @(negedge clk);
    check("ign_ready_after", 32'(bus.ready_o), 32'd1);
    @(negedge clk);
    check("ign_no_queued_done", 32'(bus.done_o), 32'd0);

    // start held high through DONE: accepted again in the following IDLE cycle
    bus.ALU_Operation_i = 4'd0;
    bus.A_i             = 32'd1;
    bus.B_i             = 32'd2;
    bus.start_i         = 1'b1;
    @(negedge clk);
    check("hold_done1",   32'(bus.done_o), 32'd1);
    check("hold_result1", bus.ALU_Result_o, 32'd3);
    bus.A_i = 32'd10;
    bus.B_i = 32'd20;
    @(negedge clk);
    check("hold_gap_done",  32'(bus.done_o), 32'd0);
    check("hold_gap_ready", 32'(bus.ready_o), 32'd1);
    check("hold_gap_res",   bus.ALU_Result_o, 32'd3);
    @(negedge clk);
    bus.start_i = 1'b0;
    check("hold_done2",   32'(bus.done_o), 32'd1);
    check("hold_result2", bus.ALU_Result_o, 32'd30);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
